axi_stream_packer: RTL and testbench



---
 rtl/axi_stream_packer_if.sv | 25 ++
 rtl/axi_stream_packer.sv | 127 ++++++++++++
 tb/tb_axi_stream_packer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_packer_if.sv
// Valid/ready bundle between the FIFO read side, the packer and the wide-word consumer.
// The slave modport is the packer's view; master is the environment driving it.
interface axi_stream_packer_if #(
   parameter int DSIZE = 8,
   parameter int RATIO = 4
);
   logic                   i_s_vld;
   logic [DSIZE-1:0]       i_s_data;
   logic                   o_s_rdy;
   logic                   i_flush;
   logic                   o_m_vld;
   logic [DSIZE*RATIO-1:0] o_m_data;
   logic [RATIO-1:0]       o_m_keep;
   logic                   i_m_rdy;

   modport slave (
      input  i_s_vld, i_s_data, i_flush, i_m_rdy,
      output o_s_rdy, o_m_vld, o_m_data, o_m_keep
   );

   modport master (
      output i_s_vld, i_s_data, i_flush, i_m_rdy,
      input  o_s_rdy, o_m_vld, o_m_data, o_m_keep
   );
endinterface

// File: rtl/axi_stream_packer.sv
// Packs RATIO narrow beats into one wide word with per-lane keep; partial words
// leave on an explicit flush or after TIMEOUT idle cycles.
//
//   state | meaning
//   EMPTY | accumulator empty (acc_cnt = 0), waiting for the first beat of a word
//   FILL  | 1..RATIO-1 beats held; leaves on completion or flush emit
module axi_stream_packer #(
   parameter int DSIZE   = 8,
   parameter int RATIO   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                ar_clk,
   input  logic                ar_rst_n,
   axi_stream_packer_if.slave  bus
);
   localparam int W  = DSIZE * RATIO;
   localparam int CW = $clog2(RATIO);
   localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] LAST   = CW'(RATIO - 1);
   localparam logic [IW-1:0] TO_MAX = IW'(TIMEOUT);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FILL  = 1'b1;

   logic [0:0]       state;
   logic [CW-1:0]    acc_cnt;
   logic [W-1:0]     acc;
   logic [W-1:0]     full_word;
   logic [IW-1:0]    idle;
   logic             flush_pend;
   logic             run;
   logic             m_vld;
   logic [W-1:0]     m_data;
   logic [RATIO-1:0] m_keep;
   logic [RATIO-1:0] part_keep;
   logic             slot_free;
   logic             timeout_hit;
   logic             flush_emit;
   logic             s_rdy;
   logic             accept;
   logic             complete;

   always_comb begin
      slot_free   = !m_vld || bus.i_m_rdy;
      timeout_hit = (TIMEOUT != 0) && (idle == TO_MAX);
      flush_emit  = (state == ST_FILL) && slot_free &&
                    (flush_pend || bus.i_flush || timeout_hit);
      // run keeps the input closed until the first edge after reset release
      s_rdy       = run && !flush_emit && ((acc_cnt != LAST) || slot_free);
      accept      = bus.i_s_vld && s_rdy;
      complete    = accept && (acc_cnt == LAST);
      full_word   = acc;
      full_word[(RATIO-1)*DSIZE +: DSIZE] = bus.i_s_data;
      for (int k = 0; k < RATIO; k++) begin
         part_keep[k] = (k < int'(acc_cnt));
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         state   <= ST_EMPTY;
         acc_cnt <= '0;
         acc     <= '0;
      end else if (complete || flush_emit) begin
         state   <= ST_EMPTY;
         acc_cnt <= '0;
         acc     <= '0;
      end else if (accept) begin
         state   <= ST_FILL;
         acc_cnt <= acc_cnt + 1'b1;
         acc[int'(acc_cnt)*DSIZE +: DSIZE] <= bus.i_s_data;
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         flush_pend <= 1'b0;
      end else if (flush_emit) begin
         flush_pend <= 1'b0;
      end else if (bus.i_flush && ((state == ST_FILL) || accept)) begin
         flush_pend <= 1'b1;
      end
   end

   // Saturates at TIMEOUT, so a hit blocked by backpressure stays armed.
   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         idle <= '0;
      end else if (accept || flush_emit || (state == ST_EMPTY)) begin
         idle <= '0;
      end else if (idle != TO_MAX) begin
         idle <= idle + 1'b1;
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         m_vld  <= 1'b0;
         m_data <= '0;
         m_keep <= '0;
      end else if (complete) begin
         m_vld  <= 1'b1;
         m_data <= full_word;
         m_keep <= '1;
      end else if (flush_emit) begin
         m_vld  <= 1'b1;
         m_data <= acc;
         m_keep <= part_keep;
      end else if (m_vld && bus.i_m_rdy) begin
         m_vld  <= 1'b0;
      end
   end

   assign bus.o_s_rdy  = s_rdy;
   assign bus.o_m_vld  = m_vld;
   assign bus.o_m_data = m_data;
   assign bus.o_m_keep = m_keep;
endmodule

// File: tb/tb_axi_stream_packer.sv
// Directed bench for axi_stream_packer: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares on every output handshake.
module tb_axi_stream_packer;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [35:0] exp_q[$];
   logic        held;
   logic [31:0] prev_data;
   logic [3:0]  prev_keep;
   bit          stream_done;

   axi_stream_packer_if #(.DSIZE(8), .RATIO(4)) bus ();

   axi_stream_packer #(.DSIZE(8), .RATIO(4), .TIMEOUT(16)) dut (
      .ar_clk   (clk),
      .ar_rst_n (rst_n),
      .bus      (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
      exp_q.push_back({k, d});
   endtask

   task automatic send(input logic [7:0] b, output int waits);
      bit hs;
      hs = 1'b0;
      waits = 0;
      bus.i_s_vld  = 1'b1;
      bus.i_s_data = b;
      while (!hs && waits < 200) begin
         @(negedge clk);
         hs = bus.o_s_rdy;
         @(posedge clk);
         #1;
         if (!hs) waits++;
      end
      if (!hs) begin
         errors++;
         $display("FAIL send_timeout: beat %0h never accepted", b);
      end
      bus.i_s_vld = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor: hold-stability plus scoreboard pop on each handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_vld",  {63'd0, bus.o_m_vld}, 64'd1);
            chk("hold_data", {32'd0, bus.o_m_data}, {32'd0, prev_data});
            chk("hold_keep", {60'd0, bus.o_m_keep}, {60'd0, prev_keep});
         end
         if (bus.o_m_vld && bus.i_m_rdy) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_word: got %0h keep %0h expected none",
                        bus.o_m_data, bus.o_m_keep);
            end else begin
               logic [35:0] e;
               e = exp_q.pop_front();
               chk("word_data", {32'd0, bus.o_m_data}, {32'd0, e[31:0]});
               chk("word_keep", {60'd0, bus.o_m_keep}, {60'd0, e[35:32]});
            end
         end
         held      = bus.o_m_vld && !bus.i_m_rdy;
         prev_data = bus.o_m_data;
         prev_keep = bus.o_m_keep;
      end
   end

   initial begin
      int w;
      int n;
      logic [7:0] t1 [4];
      checks = 0;
      errors = 0;
      held = 1'b0;
      bus.i_s_vld  = 1'b0;
      bus.i_s_data = '0;
      bus.i_flush  = 1'b0;
      bus.i_m_rdy  = 1'b1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      cycles(3);
      chk("rst_vld",  {63'd0, bus.o_m_vld}, 64'd0);
      chk("rst_data", {32'd0, bus.o_m_data}, 64'd0);
      chk("rst_keep", {60'd0, bus.o_m_keep}, 64'd0);
      chk("rst_srdy", {63'd0, bus.o_s_rdy}, 64'd0);
      rst_n = 1'b1;
      cycles(2);

      // full word, consecutive beats, no backpressure
      t1[0] = 8'h11; t1[1] = 8'h22; t1[2] = 8'h33; t1[3] = 8'h44;
      expect_word(32'h44332211, 4'hF);
      for (int i = 0; i < 4; i++) begin
         send(t1[i], w);
         chk("t1_no_stall", w, 0);
      end
      chk("t1_vld_latency", {63'd0, bus.o_m_vld}, 64'd1);
      cycles(3);

      // backpressure with 12 beats
      bus.i_m_rdy = 1'b0;
      expect_word(32'h04030201, 4'hF);
      expect_word(32'h08070605, 4'hF);
      expect_word(32'h0C0B0A09, 4'hF);
      stream_done = 1'b0;
      fork
         begin
            int ww;
            for (int i = 1; i <= 12; i++) send(8'(i), ww);
            stream_done = 1'b1;
         end
      join_none
      cycles(14);
      @(negedge clk);
      chk("t2_srdy_low",  {63'd0, bus.o_s_rdy}, 64'd0);
      chk("t2_held_data", {32'd0, bus.o_m_data}, 64'h04030201);
      @(posedge clk); #1;
      bus.i_m_rdy = 1'b1;
      n = 0;
      while (!stream_done && n < 100) begin
         cycles(1);
         n++;
      end
      chk("t2_stream_done", {63'd0, stream_done}, 64'd1);
      cycles(3);

      // idle timeout flush of a 2-lane word
      expect_word(32'h0000A2A1, 4'h3);
      send(8'hA1, w);
      send(8'hA2, w);
      n = 0;
      while (n < 100) begin
         cycles(1);
         n++;
         if (bus.o_m_vld) break;
      end
      chk("t3_timeout_cycles", n, 17);
      cycles(2);

      // flush request held pending under backpressure
      bus.i_m_rdy = 1'b0;
      expect_word(32'hB4B3B2B1, 4'hF);
      expect_word(32'h00000055, 4'h1);
      send(8'hB1, w); send(8'hB2, w); send(8'hB3, w); send(8'hB4, w);
      send(8'h55, w);
      bus.i_flush = 1'b1;
      cycles(1);
      bus.i_flush = 1'b0;
      cycles(5);
      chk("t4_pend_held", {32'd0, bus.o_m_data}, 64'hB4B3B2B1);
      bus.i_m_rdy = 1'b1;
      cycles(3);
      bus.i_flush = 1'b1;
      cycles(1);
      bus.i_flush = 1'b0;
      cycles(4);
      chk("t4_no_empty_word", {63'd0, bus.o_m_vld}, 64'd0);

      // flush and beat in the same cycle at acc_cnt=2
      expect_word(32'h0000C2C1, 4'h3);
      expect_word(32'hC6C5C4C3, 4'hF);
      send(8'hC1, w);
      send(8'hC2, w);
      bus.i_s_vld  = 1'b1;
      bus.i_s_data = 8'hC3;
      bus.i_flush  = 1'b1;
      @(negedge clk);
      chk("t5_srdy_blocked", {63'd0, bus.o_s_rdy}, 64'd0);
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      send(8'hC3, w);
      send(8'hC4, w); send(8'hC5, w); send(8'hC6, w);
      cycles(3);

      // reset mid-word while a word is held
      bus.i_m_rdy = 1'b0;
      send(8'hD1, w); send(8'hD2, w); send(8'hD3, w); send(8'hD4, w);
      send(8'hE1, w); send(8'hE2, w); send(8'hE3, w);
      chk("t6_vld_before_rst", {63'd0, bus.o_m_vld}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld",  {63'd0, bus.o_m_vld}, 64'd0);
      chk("t6_rst_srdy", {63'd0, bus.o_s_rdy}, 64'd0);
      cycles(2);
      rst_n = 1'b1;
      bus.i_m_rdy = 1'b1;
      expect_word(32'hF4F3F2F1, 4'hF);
      send(8'hF1, w); send(8'hF2, w); send(8'hF3, w); send(8'hF4, w);
      cycles(5);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
